// File: rtl/register_bank_mp_pkg.sv
// Shared definitions for the multi-port register bank: write-port op codes and default geometry.
package register_bank_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_INC   = 2'b10,
      OP_DEC   = 2'b11
   } op_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/register_bank_mp_incdec_unit.sv
// Combinational increment/decrement of one register value with carry/borrow and zero status.
module incdec_unit
   import register_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] old_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] next_o,
   output logic             carry_o,
   output logic             zero_o
);

   always_comb begin
      next_o  = old_i;
      carry_o = 1'b0;
      case (op_i)
         OP_INC: begin
            next_o  = old_i + WIDTH'(1);
            carry_o = &old_i;
         end
         OP_DEC: begin
            next_o  = old_i - WIDTH'(1);
            carry_o = ~|old_i;
         end
         default: ;
      endcase
      zero_o = ~|next_o;
   end

endmodule

// File: rtl/register_bank_mp.sv
// Register bank with one write/modify port (WRITE/INC/DEC) and two registered read ports
// with write-first bypass, feeding both ALU operands in a single cycle.
module register_bank_mp
   import register_bank_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       op,
   input  logic [AW-1:0]    ws,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   input  logic [AW-1:0]    rs_a,
   input  logic [AW-1:0]    rs_b,
   output logic [WIDTH-1:0] dout_a,
   output logic [WIDTH-1:0] dout_b,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] dout_a_q, dout_a_d;
   logic [WIDTH-1:0] dout_b_q, dout_b_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] idu_next;
   logic             idu_carry;
   logic             idu_zero;
   logic [WIDTH-1:0] wr_val;
   logic             wr_commit;
   logic             flag_upd;

   incdec_unit #(.WIDTH(WIDTH)) u_incdec (
      .old_i   (mem_q[ws]),
      .op_i    (op),
      .next_o  (idu_next),
      .carry_o (idu_carry),
      .zero_o  (idu_zero)
   );

   assign wr_commit = en && (op != OP_NOP);
   assign flag_upd  = en && ((op == OP_INC) || (op == OP_DEC));
   assign wr_val    = (op == OP_WRITE) ? din : idu_next;

   always_comb begin
      mem_d    = mem_q;
      dout_a_d = dout_a_q;
      dout_b_d = dout_b_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      if (wr_commit) begin
         mem_d[ws] = wr_val;
      end
      if (flag_upd) begin
         carry_d = idu_carry;
         zero_d  = idu_zero;
      end
      // Same-cycle write to the selected register is forwarded so reads see the new value.
      if (rd_en) begin
         dout_a_d = (wr_commit && (rs_a == ws)) ? wr_val : mem_q[rs_a];
         dout_b_d = (wr_commit && (rs_b == ws)) ? wr_val : mem_q[rs_b];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         dout_a_q <= '0;
         dout_b_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         dout_a_q <= dout_a_d;
         dout_b_q <= dout_b_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;
   assign carry  = carry_q;
   assign zero   = zero_q;

endmodule
